// File: rtl/alu_types.sv
// alu_types: shared ALU op encoding, RV32I decode constants and sequencer states.
package alu_types;
    localparam int N = 32;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_control_t;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} seq_state_t;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    // funct3 -> ALU op shared by OP and OP-IMM; alt selects SUB/SRA
    function automatic alu_control_t f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/response handshakes plus the ALU connection of the sequencer.
interface alu_sequencer_if;
    import alu_types::*;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  instr;
    logic [N-1:0] rs1_val;
    logic [N-1:0] rs2_val;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    alu_control_t alu_control;
    logic [N-1:0] alu_result;
    logic         alu_overflow;
    logic         alu_zero;
    logic         alu_equal;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic [4:0]   out_rd;
    logic         out_wr_en;
    logic         out_branch;
    logic         out_taken;
    logic         out_overflow;
    logic         out_illegal;
    modport master (
        input  in_valid, instr, rs1_val, rs2_val, alu_result, alu_overflow, alu_zero, alu_equal, out_ready,
        output in_ready, alu_a, alu_b, alu_control, out_valid, out_result, out_rd, out_wr_en,
        output out_branch, out_taken, out_overflow, out_illegal
    );
    modport slave (
        output in_valid, instr, rs1_val, rs2_val, alu_result, alu_overflow, alu_zero, alu_equal, out_ready,
        input  in_ready, alu_a, alu_b, alu_control, out_valid, out_result, out_rd, out_wr_en,
        input  out_branch, out_taken, out_overflow, out_illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: combinational RV32I OP/OP-IMM/BRANCH decode into ALU control and operand-b select.
module alu_decoder
    import alu_types::*;
(
    input  logic [31:0]  instr,
    output alu_control_t alu_control,
    output logic         use_imm,
    output logic [N-1:0] imm,
    output logic         is_branch,
    output logic [2:0]   branch_kind,
    output logic         illegal
);
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic       shift;
    logic       unused;
    assign opcode = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign shift = f3 == 3'b001 || f3 == 3'b101;
    assign branch_kind = f3;
    assign unused = ^{instr[19:15], instr[11:7]};
    always_comb begin
        alu_control = ALU_ADD;
        use_imm = 1'b0;
        imm = {{20{instr[31]}}, instr[31:20]};
        is_branch = 1'b0;
        illegal = 1'b1;
        case (opcode)
            OPC_OP: begin
                alu_control = f3_op(f3, f7 == F7_ALT);
                illegal = !(f7 == F7_ZERO || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                alu_control = f3_op(f3, f3 == 3'b101 && f7 == F7_ALT);
                imm = shift ? {27'b0, instr[24:20]} : imm;
                illegal = shift && !(f7 == F7_ZERO || (f3 == 3'b101 && f7 == F7_ALT));
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                alu_control = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                illegal = f3[2:1] == 2'b01;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: three-state initiator that feeds the external ALU and registers its response.
module alu_sequencer
    import alu_types::*;
(
    input logic            clk,
    input logic            rst_n,
    alu_sequencer_if.master bus
);
    seq_state_t   state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic [N-1:0] rs1_q, rs1_d, rs2_q, rs2_d, result_q, result_d;
    logic         wr_en_q, wr_en_d, branch_q, branch_d, taken_q, taken_d;
    logic         overflow_q, overflow_d, illegal_q, illegal_d;
    logic [31:0]  dec_instr;
    alu_control_t dec_ctrl;
    logic         dec_use_imm, dec_branch, dec_illegal, cond, unused;
    logic [N-1:0] dec_imm;
    logic [2:0]   dec_kind;
    // Decode the incoming word while idle (illegal check) and the latched word otherwise
    assign dec_instr = state_q == S_IDLE ? bus.instr : instr_q;
    alu_decoder u_dec (
        .instr       (dec_instr),
        .alu_control (dec_ctrl),
        .use_imm     (dec_use_imm),
        .imm         (dec_imm),
        .is_branch   (dec_branch),
        .branch_kind (dec_kind),
        .illegal     (dec_illegal)
    );
    assign bus.alu_a = rs1_q;
    assign bus.alu_b = dec_use_imm ? dec_imm : rs2_q;
    assign bus.alu_control = dec_ctrl;
    // funct3[2] picks SLT/SLTU result over equality; funct3[0] inverts the condition
    assign cond = (dec_kind[2] ? bus.alu_result[0] : bus.alu_equal) ^ dec_kind[0];
    assign unused = ^{bus.alu_zero, dec_kind[1]};
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        result_d = result_q;
        wr_en_d = wr_en_q;
        branch_d = branch_q;
        taken_d = taken_q;
        overflow_d = overflow_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                instr_d = bus.instr;
                rs1_d = bus.rs1_val;
                rs2_d = bus.rs2_val;
                state_d = dec_illegal ? S_DONE : S_EXEC;
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    result_d = '0;
                    wr_en_d = 1'b0;
                    branch_d = 1'b0;
                    taken_d = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            S_EXEC: begin
                result_d = bus.alu_result;
                overflow_d = bus.alu_overflow;
                branch_d = dec_branch;
                taken_d = dec_branch & cond;
                wr_en_d = !dec_branch && instr_q[11:7] != 5'd0;
                illegal_d = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: state_d = bus.out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            result_q <= '0;
            wr_en_q <= 1'b0;
            branch_q <= 1'b0;
            taken_q <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            result_q <= result_d;
            wr_en_q <= wr_en_d;
            branch_q <= branch_d;
            taken_q <= taken_d;
            overflow_q <= overflow_d;
            illegal_q <= illegal_d;
        end
    end
    assign bus.in_ready = state_q == S_IDLE;
    assign bus.out_valid = state_q == S_DONE;
    assign bus.out_result = result_q;
    assign bus.out_rd = instr_q[11:7];
    assign bus.out_wr_en = wr_en_q;
    assign bus.out_branch = branch_q;
    assign bus.out_taken = taken_q;
    assign bus.out_overflow = overflow_q;
    assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random instructions checked against an RV32I-level reference model.
module tb_alu_sequencer;
    import alu_types::*;
    typedef struct packed {
        logic        illegal;
        logic        branch;
        logic        taken;
        logic        wr_en;
        logic        ovf;
        logic [31:0] res;
        logic [31:0] opb;
        logic [4:0]  rd;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    alu_sequencer_if bus ();
    alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // Stand-in for the shared combinational ALU
    always_comb begin
        bus.alu_result = '0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_control)
            ALU_ADD: begin
                bus.alu_result = bus.alu_a + bus.alu_b;
                bus.alu_overflow = bus.alu_a[31] == bus.alu_b[31] && bus.alu_result[31] != bus.alu_a[31];
            end
            ALU_SUB: begin
                bus.alu_result = bus.alu_a - bus.alu_b;
                bus.alu_overflow = bus.alu_a[31] != bus.alu_b[31] && bus.alu_result[31] != bus.alu_a[31];
            end
            ALU_SLL:  bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            ALU_SLT:  bus.alu_result = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            ALU_SLTU: bus.alu_result = {31'b0, bus.alu_a < bus.alu_b};
            ALU_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
            ALU_SRL:  bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            ALU_SRA:  bus.alu_result = $signed(bus.alu_a) >>> bus.alu_b[4:0];
            ALU_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
            ALU_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            default:  bus.alu_result = '0;
        endcase
        bus.alu_equal = bus.alu_a == bus.alu_b;
        bus.alu_zero = bus.alu_result == '0;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask
    function automatic logic ovf(input longint s);
        return s > 64'sd2147483647 || s < -64'sd2147483648;
    endfunction
    function automatic exp_t ref_model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] imm;
        logic [4:0] sh;
        longint sa, sb, simm;
        imm = {{20{i[31]}}, i[31:20]};
        sh = i[24:20];
        sa = $signed(a);
        sb = $signed(b);
        simm = $signed(imm);
        e = '0;
        e.rd = i[11:7];
        e.illegal = 1'b1;
        e.opb = b;
        if (i[6:0] == 7'h33) begin
            e.illegal = 1'b0;
            case ({i[31:25], i[14:12]})
                {7'h00, 3'd0}: begin e.res = a + b; e.ovf = ovf(sa + sb); end
                {7'h20, 3'd0}: begin e.res = a - b; e.ovf = ovf(sa - sb); end
                {7'h00, 3'd1}: e.res = a << b[4:0];
                {7'h00, 3'd2}: e.res = {31'b0, sa < sb};
                {7'h00, 3'd3}: e.res = {31'b0, a < b};
                {7'h00, 3'd4}: e.res = a ^ b;
                {7'h00, 3'd5}: e.res = a >> b[4:0];
                {7'h20, 3'd5}: e.res = 32'($signed(a) >>> b[4:0]);
                {7'h00, 3'd6}: e.res = a | b;
                {7'h00, 3'd7}: e.res = a & b;
                default: e.illegal = 1'b1;
            endcase
        end else if (i[6:0] == 7'h13) begin
            e.illegal = 1'b0;
            e.opb = imm;
            case (i[14:12])
                3'd0: begin e.res = a + imm; e.ovf = ovf(sa + simm); end
                3'd2: e.res = {31'b0, sa < simm};
                3'd3: e.res = {31'b0, a < imm};
                3'd4: e.res = a ^ imm;
                3'd6: e.res = a | imm;
                3'd7: e.res = a & imm;
                3'd1: begin e.opb = {27'b0, sh}; e.res = a << sh; e.illegal = i[31:25] != 7'h00; end
                default: begin
                    e.opb = {27'b0, sh};
                    e.res = i[31:25] == 7'h20 ? 32'($signed(a) >>> sh) : a >> sh;
                    e.illegal = i[31:25] != 7'h00 && i[31:25] != 7'h20;
                end
            endcase
        end else if (i[6:0] == 7'h63) begin
            e.illegal = 1'b0;
            e.branch = 1'b1;
            case (i[14:12])
                3'd0: begin e.res = a - b; e.ovf = ovf(sa - sb); e.taken = a == b; end
                3'd1: begin e.res = a - b; e.ovf = ovf(sa - sb); e.taken = a != b; end
                3'd4: begin e.res = {31'b0, sa < sb}; e.taken = sa < sb; end
                3'd5: begin e.res = {31'b0, sa < sb}; e.taken = sa >= sb; end
                3'd6: begin e.res = {31'b0, a < b}; e.taken = a < b; end
                3'd7: begin e.res = {31'b0, a < b}; e.taken = a >= b; end
                default: e.illegal = 1'b1;
            endcase
        end
        if (e.illegal) begin
            e.res = '0;
            e.ovf = 1'b0;
            e.branch = 1'b0;
            e.taken = 1'b0;
        end
        e.wr_en = !e.illegal && !e.branch && e.rd != 5'd0;
        return e;
    endfunction
    task automatic check_out(input exp_t e);
        chk("out_valid", bus.out_valid, 1);
        chk("in_ready_busy", bus.in_ready, 0);
        chk("out_result", bus.out_result, e.res);
        chk("out_rd", bus.out_rd, e.rd);
        chk("out_wr_en", bus.out_wr_en, e.wr_en);
        chk("out_branch", bus.out_branch, e.branch);
        chk("out_taken", bus.out_taken, e.taken);
        chk("out_overflow", bus.out_overflow, e.ovf);
        chk("out_illegal", bus.out_illegal, e.illegal);
    endtask
    task automatic accept(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.instr = i;
        bus.rs1_val = a;
        bus.rs2_val = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.instr = $urandom;
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
    endtask
    task automatic run(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int n;
        e = ref_model(i, a, b);
        accept(i, a, b);
        if (!e.illegal) begin
            chk("alu_a", bus.alu_a, a);
            chk("alu_b", bus.alu_b, e.opb);
        end
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, e.illegal ? 1 : 2);
        for (int h = 0; h <= hold; h++) begin
            check_out(e);
            if (h < hold) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("in_ready_after", bus.in_ready, 1);
        chk("out_valid_after", bus.out_valid, 0);
    endtask
    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k <= 3) r[6:0] = 7'h33;
        else if (k <= 6) r[6:0] = 7'h13;
        else if (k <= 8) r[6:0] = 7'h63;
        if (k <= 6 && $urandom_range(0, 3) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return r;
    endfunction
    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction
    initial begin
        logic [31:0] a;
        bus.in_valid = 1'b0;
        bus.instr = '0;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_rd", bus.out_rd, 0);
        chk("rst_out_flags", {bus.out_wr_en, bus.out_branch, bus.out_taken, bus.out_overflow, bus.out_illegal}, 0);
        rst_n = 1'b1;
        run(32'h002082B3, 32'd7, 32'd5, 0);
        run(32'h402081B3, 32'h8000_0000, 32'd1, 0);
        run(32'h4040D313, 32'hF000_0000, $urandom, 0);
        run(32'h0020C063, 32'hFFFF_FFFF, 32'd1, 0);
        run(32'h0020E063, 32'hFFFF_FFFF, 32'd1, 0);
        run(32'h0000007F, 32'd3, 32'd4, 0);
        run(32'h002082B3, 32'd100, 32'd23, 3);
        run(32'h0000007F, 32'd1, 32'd2, 3);
        accept(32'h002082B3, 32'd7, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("postrst_out_valid", bus.out_valid, 0);
            chk("postrst_in_ready", bus.in_ready, 1);
        end
        chk("postrst_out_result", bus.out_result, 0);
        for (int t = 0; t < 200; t++) begin
            a = rand_val();
            run(rand_instr(), a, $urandom_range(0, 3) == 0 ? a : rand_val(), $urandom_range(0, 2));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
